mips_pc_sequencer: RTL



---
 rtl/mips_pc_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mips_pc_sequencer.sv
// Multi-cycle fetch / next-PC sequencer for the MIPS core.
// Define FETCH_TIMEOUT_EN to enable the fetch wait watchdog (fetch_fault).
module mips_pc_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned JUMP_MODE     = 0,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        ex_done,
    input  logic        alu_zero,
    output logic [31:0] pc,
    output logic        halt,
    output logic        fetch_fault
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_HALT = 6'b111111;

`ifdef FETCH_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;
    logic        fault_q, fault_d;

    logic [31:0] pc4, br_tgt, jmp_tgt, next_pc;
    logic        fetch_timeout;

    always_comb begin
        pc4    = pc_q + 32'd4;
        br_tgt = pc4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (JUMP_MODE == 0) begin
            jmp_tgt = {pc4[31:28], instr_q[25:0], 2'b00};
        end else begin
            jmp_tgt = pc4 + {{4{instr_q[25]}}, instr_q[25:0], 2'b00};
        end
        case (instr_q[31:26])
            OP_J, OP_JAL: next_pc = jmp_tgt;
            OP_BEQ:       next_pc = alu_zero ? br_tgt : pc4;
            OP_BNE:       next_pc = alu_zero ? pc4 : br_tgt;
            default:      next_pc = pc4;
        endcase
    end

    // Counter is held at zero when the watchdog is compiled out, so it folds away.
    assign fetch_timeout = TimeoutEn && ((cnt_q + 32'd1) == FETCH_TIMEOUT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        valid_d = 1'b0;
        halt_d  = halt_q;
        fault_d = fault_q;
        case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
                req_d   = 1'b1;
                cnt_d   = 32'd0;
            end
            ST_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_EXEC;
                end else if (fetch_timeout) begin
                    fault_d = 1'b1;
                    halt_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = ST_HALT;
                end else if (TimeoutEn) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_EXEC: begin
                if (ex_done) begin
                    if (instr_q[31:26] == OP_HALT) begin
                        halt_d  = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d    = next_pc;
                        req_d   = 1'b1;
                        cnt_d   = 32'd0;
                        state_d = ST_FETCH;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            cnt_q   <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
            fault_q <= fault_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign halt        = halt_q;
    assign fetch_fault = fault_q;

endmodule
